// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide, one bit per cycle; result DATA_WIDTH+1 edges after accept (1 for divide-by-zero/overflow).
// Valid/ready on both sides: in_ready only in IDLE, result held in DONE until out_ready.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]     op_q;
  logic [W-1:0]   acc, low, opnd_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic           neg_q, rneg_q, spec_q;

  logic           accept, is_div_in, sa_in, sb_in, a_neg, b_neg, div0, ovf, special;
  logic [W-1:0]   mag_a, mag_b, spec_res;
  logic [W:0]     mul_sum, tmp;
  logic [W-1:0]   diff;
  logic           ge;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo, rem, result_fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Operand decode at accept: signedness, magnitudes and the two divide special cases
  always_comb begin
    is_div_in = Operation[2];
    sa_in     = Operation[2] ? ~Operation[0] : (Operation[1:0] == 2'b01) || (Operation[1:0] == 2'b10);
    sb_in     = Operation[2] ? ~Operation[0] : (Operation[1:0] == 2'b01);
    a_neg     = sa_in & SrcA[W-1];
    b_neg     = sb_in & SrcB[W-1];
    mag_a     = a_neg ? -SrcA : SrcA;
    mag_b     = b_neg ? -SrcB : SrcB;
    div0      = (SrcB == '0);
    ovf       = sb_in && (SrcA == {1'b1, {(W-1){1'b0}}}) && (&SrcB);
    special   = is_div_in && (div0 || ovf);
    if (div0) spec_res = Operation[1] ? SrcA : '1;
    else      spec_res = Operation[1] ? '0 : SrcA;
  end

  // Mul keeps {acc,low} as product/multiplier; div keeps acc=remainder, low=dividend->quotient
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, opnd_q};
    tmp     = {acc, low[W-1]};
    ge      = (tmp >= {1'b0, opnd_q});
    diff    = tmp[W-1:0] - opnd_q;
    prod    = {acc, low};
    prod_s  = neg_q ? -prod : prod;
    quo     = neg_q ? -low : low;
    rem     = rneg_q ? -acc : acc;
    if (spec_q)       result_fin = low;
    else if (op_q[2]) result_fin = op_q[1] ? rem : quo;
    else              result_fin = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      acc       <= '0;
      low       <= '0;
      opnd_q    <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      spec_q    <= 1'b0;
      ALUResult <= '0;
    end else if (accept) begin
      op_q   <= Operation[2:0];
      acc    <= '0;
      spec_q <= special;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      opnd_q <= is_div_in ? mag_b : mag_a;
      // A zero count makes the next CALC edge finalize straight away
      cnt    <= special ? '0 : CNT_WIDTH'(W);
      if (special)        low <= spec_res;
      else if (is_div_in) low <= mag_a;
      else                low <= mag_b;
    end else if (state == CALC && !flush) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (op_q[2]) begin
          acc <= ge ? diff : tmp[W-1:0];
          low <= {low[W-2:0], ge};
        end else if (low[0]) begin
          {acc, low} <= {mul_sum, low[W-1:1]};
        end else begin
          {acc, low} <= {1'b0, acc, low[W-1:1]};
        end
      end else begin
        ALUResult <= result_fin;
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: RV32M vectors, special divides, backpressure, flush and async reset.
module tb_alu_muldiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [2:0]  Operation = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] ALUResult;

  int passed = 0;
  int total  = 0;

  logic [31:0] res;
  int          lat;
  bit          stall_ok, stable, seen;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  alu_muldiv dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issues one op from IDLE, waits (bounded) for out_valid, then hands off if out_ready is high
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int l, output bit ok);
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0; ok = 1'b1;
    while (!out_valid && l < 100) begin
      if (in_ready || !busy) ok = 1'b0;
      @(posedge clk); #1;
      l++;
    end
    r = ALUResult;
    if (out_ready && out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_l);
    logic [31:0] r;
    int          l;
    bit          ok;
    run_op(op, a, b, r, l, ok);
    chk({tag, "_res"}, r, exp_r);
    chk({tag, "_lat"}, l, exp_l);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", ALUResult, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(MUL, 32'd7, 32'hFFFF_FFFD, res, lat, stall_ok);
    chk("mul_res", res, 32'hFFFF_FFEB);
    chk("mul_lat", lat, 33);
    chk("mul_stall", stall_ok, 1);
    chk("mul_handoff_in_ready", in_ready, 1);
    chk("mul_handoff_out_valid", out_valid, 0);

    do_case("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_case("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_case("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_case("div",    DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_case("rem",    REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_case("divu",   DIVU,   32'd100,       32'd7,         32'd14,        33);
    do_case("remu",   REMU,   32'd100,       32'd7,         32'd2,         33);

    do_case("divu_by0", DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_case("rem_by0",  REM,  32'd5,         32'd0,         32'd5,         1);
    do_case("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_case("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    out_ready = 1'b0;
    run_op(DIVU, 32'd1000, 32'd10, res, lat, stall_ok);
    chk("bp_res", res, 32'd100);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ALUResult !== 32'd100 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready", in_ready, 1);
    chk("bp_out_valid", out_valid, 0);

    @(negedge clk);
    Operation = MUL; SrcA = 32'h0000_FFFF; SrcB = 32'h0000_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_keeps_result", ALUResult, 32'd100);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", seen, 0);
    do_case("mul_after_flush", MUL, 32'd3, 32'd4, 32'd12, 33);

    @(negedge clk);
    Operation = MUL; SrcA = 32'd5; SrcB = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", ALUResult, 0);
    @(negedge clk) rst_n = 1'b1;
    do_case("remu_after_rst", REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit implementing the full RV32M operation set; runs alongside the combinational ALU in the execute stage.
- Operands and operation are accepted through a valid/ready handshake. The unit computes one bit per cycle and holds the result until the consumer takes it.
- The hazard unit stalls the pipeline while `in_ready` is low or the result is pending.
- `flush` aborts an in-flight operation on a branch mispredict or trap.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; legal values are even and ≥ 4.
- OPCODE_LENGTH, 3, width of `Operation`. The encoding equals RISC-V funct3 for OP=0110011, funct7=0000001.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; the unit returns to IDLE on the next edge
- in_valid  in  1  SrcA/SrcB/Operation are valid
- in_ready  out  1  unit can accept an operation (high only in IDLE)
- SrcA  in  DATA_WIDTH  rs1 value
- SrcB  in  DATA_WIDTH  rs2 value
- Operation  in  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- out_valid  out  1  ALUResult holds a finished result
- out_ready  in  1  consumer accepts the result
- ALUResult  out  DATA_WIDTH  result; held stable while out_valid=1 and out_ready=0
- busy  out  1  state is CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, ALUResult=0.
  - Counter and internal registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - An in_valid&&in_ready edge latches operands, op, and operand signs, then enters CALC with counter=DATA_WIDTH.
  - Signed ops (MUL*, DIV, REM) convert operands to magnitudes according to the signedness rules. MULHSU treats SrcA as signed and SrcB as unsigned. MUL uses low bits, so sign handling does not affect it.
- Special divide cases (op 1xx) are detected at accept and bypass CALC. The next edge enters DONE with the result:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = -1, DIV/REM only): DIV gives SrcA; REM gives 0.
- CALC: each edge performs one iteration and decrements the counter.
  - Multiply: shift-add into a 2*DATA_WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - The edge on which the counter reaches 0 performs the last iteration. The next edge applies sign correction, loads ALUResult, and enters DONE.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
- Result selection:
  - MUL gives product[DATA_WIDTH-1:0]; MULH/MULHSU/MULHU give product[2*DATA_WIDTH-1:DATA_WIDTH].
  - DIV/DIVU give the quotient; REM/REMU give the remainder.
- Latency:
  - Normal ops: out_valid rises DATA_WIDTH+1 edges after the accepting edge (33 for 32 bits).
  - Special divide cases: out_valid rises 1 edge after accept.
- DONE:
  - out_valid=1, ALUResult is stable.
  - out_valid&&out_ready on an edge returns to IDLE; out_valid is low and in_ready is high after that edge.
  - A new operation is accepted no earlier than the edge after the result handoff (no same-cycle back-to-back).
- in_ready=0 in CALC and DONE. in_valid is ignored there and must be held by the producer.
- flush has priority over every transition:
  - Next state is IDLE, out_valid=0, and the result is discarded; ALUResult keeps its last value.
  - flush in IDLE together with in_valid means the operation is not accepted.
- Reset asserted mid-CALC or in DONE clears immediately; no result is produced.
- Operation values outside the encoding cannot occur, since all 8 codes are defined.

Test Plan:
- Signed MUL: MUL SrcA=7, SrcB=0xFFFFFFFD -> ALUResult=0xFFFFFFEB after exactly 33 cycles; in_ready=0 throughout CALC.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide and remainder: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special divide cases (each must give out_valid 1 cycle after accept):
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> ALUResult and out_valid stay stable and in_ready stays 0. Raising out_ready gives a handoff, with in_ready=1 on the following cycle.
- Abort and reset:
  - flush at CALC iteration 12 -> IDLE next edge, out_valid never rises, and a following MUL 3×4 returns 12.
  - rst_n low mid-CALC -> outputs take reset values immediately (asynchronously).
